// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM encoding, per-row output modes and accumulator sizing for rsa_tile.
package rsa_pkg;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} rsa_state_e;

    localparam logic [1:0] MODE_C   = 2'd0;
    localparam logic [1:0] MODE_ADD = 2'd1;
    localparam logic [1:0] MODE_SUB = 2'd2;
    localparam logic [1:0] MODE_NEG = 2'd3;

    function automatic int acc_dw(input int dw, input int l);
        return 2 * dw + $clog2(l);
    endfunction

endpackage

// File: rtl/rsa_pe.sv
// rsa_pe: one systolic MAC cell -- registered multiply, valid-gated accumulate, synchronous clear;
// forwards its A operand east and its B operand south one cycle later.
module rsa_pe
    import rsa_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = acc_dw(16, 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [DW-1:0]        a_in,
    input  logic                 av_in,
    input  logic [DW-1:0]        b_in,
    input  logic                 bv_in,
    output logic [DW-1:0]        a_out,
    output logic                 av_out,
    output logic [DW-1:0]        b_out,
    output logic                 bv_out,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] p_q, p_d;
    logic                   pv_q, pv_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [DW-1:0]          a_q, b_q;
    logic                   av_q, bv_q;

    always_comb begin
        p_d   = $signed(a_in) * $signed(b_in);
        pv_d  = av_in & bv_in;
        acc_d = clr ? '0 : pv_q ? acc_q + AW'(p_q) : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            acc_q <= '0;
            a_q   <= '0;
            av_q  <= 1'b0;
            b_q   <= '0;
            bv_q  <= 1'b0;
        end else begin
            p_q   <= p_d;
            pv_q  <= pv_d;
            acc_q <= acc_d;
            a_q   <= a_in;
            av_q  <= av_in;
            b_q   <= b_in;
            bv_q  <= bv_in;
        end
    end

    assign a_out  = a_q;
    assign av_out = av_q;
    assign b_out  = b_q;
    assign bv_out = bv_q;
    assign acc    = acc_q;

endmodule

// File: rtl/rsa_tile.sv
// rsa_tile: X-by-Y output-stationary systolic array computing C = f(A*B, M) per row mode.
// Define RSA_SAT_EN to saturate results to RSA_DW bits; otherwise they wrap.
module rsa_tile
    import rsa_pkg::*;
#(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L      = 8,
    parameter int RSA_DW = 16
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic [$clog2(L+1)-1:0]  len,
    input  logic [2*X-1:0]          M_adder_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [X*RSA_DW-1:0]     A_data,
    input  logic [Y*RSA_DW-1:0]     B_data,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [X*RSA_DW-1:0]     M_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [X*RSA_DW-1:0]     C_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);

    localparam int AW  = acc_dw(RSA_DW, L);
    localparam int EW  = AW + 1;
    localparam int LW  = $clog2(L + 1);
    localparam int CW  = $clog2(L + X + Y + 1);
    localparam int CIW = (Y > 1) ? $clog2(Y) : 1;

    rsa_state_e          state_q, state_d;
    logic [LW-1:0]       len_q, len_d;
    logic [2*X-1:0]      mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CIW-1:0]      col_q, col_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;
    logic [X*RSA_DW-1:0] c_q, c_d;
    logic                clr, in_fire, m_fire, out_fire;

    logic [RSA_DW-1:0]    a_h  [X][Y+1];
    logic                 av_h [X][Y+1];
    logic [RSA_DW-1:0]    b_v  [X+1][Y];
    logic                 bv_v [X+1][Y];
    logic signed [AW-1:0] acc  [X][Y];

    logic signed [EW-1:0] ce, me, re;

    assign in_ready  = state_q == FEED;
    assign in_fire   = in_valid & in_ready;
    // Holding m_ready low once the last column is issued stops a stray M beat sneaking in.
    assign m_ready   = (state_q == DRAIN) & (!out_valid_q | out_ready) & !out_last_q;
    assign m_fire    = m_valid & m_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign busy      = state_q != IDLE;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign C_data    = c_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        col_d   = m_fire ? col_q + CIW'(1) : col_q;
        clr     = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && len == '0) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d = FEED;
                    clr     = 1'b1;
                    len_d   = len;
                    mode_d  = M_adder_mode;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            FEED: begin
                if (in_fire) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q + CW'(1) == CW'(len_q)) ? FLUSH : FEED;
                    cnt_d   = (cnt_q + CW'(1) == CW'(len_q)) ? '0 : cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                state_d = (cnt_q == CW'(X + Y - 2)) ? DRAIN : FLUSH;
                cnt_d   = (cnt_q == CW'(X + Y - 2)) ? '0 : cnt_q + CW'(1);
            end
            DRAIN: begin
                state_d = (out_fire && out_last_q) ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_d         = c_q;
        out_valid_d = out_fire ? 1'b0 : out_valid_q;
        out_last_d  = out_fire ? 1'b0 : out_last_q;
        ce          = '0;
        me          = '0;
        re          = '0;
        if (m_fire) begin
            out_valid_d = 1'b1;
            out_last_d  = col_q == CIW'(Y - 1);
            for (int i = 0; i < X; i++) begin
                ce = EW'(acc[i][col_q]);
                me = EW'($signed(M_data[i*RSA_DW +: RSA_DW]));
                re = mode_q[2*i +: 2] == MODE_C   ? ce :
                     mode_q[2*i +: 2] == MODE_ADD ? ce + me :
                     mode_q[2*i +: 2] == MODE_SUB ? me - ce : -ce;
`ifdef RSA_SAT_EN
                c_d[i*RSA_DW +: RSA_DW] =
                    re > $signed(EW'({(RSA_DW-1){1'b1}}))    ? {1'b0, {(RSA_DW-1){1'b1}}} :
                    re < -$signed(EW'({1'b1, {(RSA_DW-1){1'b0}}})) ? {1'b1, {(RSA_DW-1){1'b0}}} :
                    RSA_DW'(re);
`else
                c_d[i*RSA_DW +: RSA_DW] = RSA_DW'(re);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            mode_q      <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            c_q         <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            c_q         <= c_d;
        end
    end

    // Row i enters the array i cycles late so it meets column j's skewed data at PE(i,j).
    for (genvar i = 0; i < X; i++) begin : g_row
        if (i == 0) begin : g_direct
            assign a_h[0][0]  = A_data[RSA_DW-1:0];
            assign av_h[0][0] = in_fire;
        end else begin : g_skew
            localparam int SW = i * (RSA_DW + 1);
            logic [SW-1:0] sr_q, sr_d;
            always_comb sr_d = (sr_q << (RSA_DW + 1)) | SW'({in_fire, A_data[i*RSA_DW +: RSA_DW]});
            always_ff @(posedge clk or posedge sys_rst) begin
                if (sys_rst) sr_q <= '0;
                else         sr_q <= sr_d;
            end
            assign {av_h[i][0], a_h[i][0]} = sr_q[SW-1 -: RSA_DW+1];
        end
    end

    for (genvar j = 0; j < Y; j++) begin : g_col
        if (j == 0) begin : g_direct
            assign b_v[0][0]  = B_data[RSA_DW-1:0];
            assign bv_v[0][0] = in_fire;
        end else begin : g_skew
            localparam int SW = j * (RSA_DW + 1);
            logic [SW-1:0] sr_q, sr_d;
            always_comb sr_d = (sr_q << (RSA_DW + 1)) | SW'({in_fire, B_data[j*RSA_DW +: RSA_DW]});
            always_ff @(posedge clk or posedge sys_rst) begin
                if (sys_rst) sr_q <= '0;
                else         sr_q <= sr_d;
            end
            assign {bv_v[0][j], b_v[0][j]} = sr_q[SW-1 -: RSA_DW+1];
        end
    end

    for (genvar i = 0; i < X; i++) begin : g_pe_r
        for (genvar j = 0; j < Y; j++) begin : g_pe_c
            rsa_pe #(.DW(RSA_DW), .AW(AW)) u_pe (
                .clk    (clk),
                .rst    (sys_rst),
                .clr    (clr),
                .a_in   (a_h[i][j]),
                .av_in  (av_h[i][j]),
                .b_in   (b_v[i][j]),
                .bv_in  (bv_v[i][j]),
                .a_out  (a_h[i][j+1]),
                .av_out (av_h[i][j+1]),
                .b_out  (b_v[i+1][j]),
                .bv_out (bv_v[i+1][j]),
                .acc    (acc[i][j])
            );
        end
    end

endmodule
